phy_rx_sync_ctrl: RTL and testbench
===================================

PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- COMMA, 8'hBC, alignment character.
- BC_COUNT, 4, consecutive commas required for lock.
- LOS_LIMIT, 8, consecutive stuck bytes before loss of sync.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_8f, in, 1, bit clock, sole clock.
- reset, in, 1, synchronous, active-high.
- data_in0, in, 1, lane-0 serial data, MSB first.
- data_in1, in, 1, lane-1 serial data, MSB first.
- byte_0, out, 8, lane-0 aligned byte.
- byte_1, out, 8, lane-1 aligned byte.
- strobe_0, out, 1, lane-0 byte-boundary pulse.
- strobe_1, out, 1, lane-1 byte-boundary pulse.
- valid_0, out, 1, lane-0 byte is payload, not COMMA.
- valid_1, out, 1, lane-1 byte is payload, not COMMA.
- active_0, out, 1, lane 0 in ACTIVE.
- active_1, out, 1, lane 1 in ACTIVE.
- all_active, out, 1, both lanes in ACTIVE.
REQ-003 The single clock SHALL be clk_8f; reset SHALL be synchronous and active-high.

Function (per lane, lanes fully independent)
REQ-004 Each rising edge SHALL shift data_in into an 8-bit shift register, MSB first: nxt = {sr[6:0], data_in}.
REQ-005 Each lane SHALL have three states: SEARCH, LOCK, ACTIVE.
REQ-006 SEARCH: on the edge where nxt==COMMA, the lane SHALL go to LOCK with bit_cnt=0 and bc_cnt=1; otherwise it SHALL remain in SEARCH.
REQ-007 In LOCK and ACTIVE, bit_cnt SHALL increment mod 8. The edge where bit_cnt==7 is a byte boundary, and nxt on that edge is the completed byte.
REQ-008 LOCK, at a byte boundary:
- byte==COMMA: bc_cnt SHALL increment; on reaching BC_COUNT the lane SHALL go to ACTIVE.
- byte!=COMMA: the lane SHALL return to SEARCH with bc_cnt=0.
REQ-009 LOCK with BC_COUNT=1 SHALL never be entered; the first comma in SEARCH SHALL go directly to ACTIVE.
REQ-010 ACTIVE, at each byte boundary, byte_x SHALL register nxt; strobe_x SHALL pulse for exactly one cycle; valid_x SHALL be (nxt!=COMMA).
REQ-011 byte_x and valid_x SHALL hold between strobes.
REQ-012 Outputs SHALL appear the cycle after the 8th bit is sampled; there is no further latency.
REQ-013 Outside ACTIVE, strobe_x, valid_x and active_x SHALL be 0, and byte_x SHALL hold its last value.
REQ-014 active_x SHALL be registered state (state==ACTIVE). all_active SHALL equal active_0 & active_1 in the same cycle.
REQ-015 The first ACTIVE strobe SHALL occur 8 cycles after the edge that completed the BC_COUNT-th comma.
REQ-016 bc_cnt SHALL saturate at BC_COUNT and never wrap.

Reset
REQ-017 reset high at any edge, including mid-byte or in ACTIVE, SHALL force SEARCH and clear sr, bit_cnt, bc_cnt, los_cnt, byte_x, strobe_x, valid_x, active_x and all_active to 0.
REQ-018 reset SHALL take priority over every other event at the same edge.

Configuration
REQ-019 With PHY_RX_SYNC_LOS_EN defined, ACTIVE SHALL count consecutive byte-boundary bytes equal to 8'h00 or 8'hFF.
- The count SHALL clear on any other byte.
- When the count reaches LOS_LIMIT, the lane SHALL go to SEARCH with that boundary's strobe suppressed.
REQ-020 With PHY_RX_SYNC_LOS_EN undefined, ACTIVE SHALL exit only via reset, and no los_cnt logic SHALL exist.

Structure
REQ-021 The shared package phy_rx_pkg SHALL hold the state encoding (SEARCH=2'd0, LOCK=2'd1, ACTIVE=2'd2) and the default COMMA, BC_COUNT and LOS_LIMIT constants.
REQ-022 Per-lane logic SHALL be sub-module phy_rx_lane_sync, instantiated twice. The top SHALL only add all_active.

Verification
REQ-023 Four 8'hBC bytes on lane 0 then 8'h5A -> active_0 rises after the 4th comma; a strobe follows 8 cycles later with byte_0=8'h5A, valid_0=1.
REQ-024 Three 8'hBC, then 8'h11, then four 8'hBC -> the lane returns to SEARCH at 8'h11, relocks, and active_0 rises only after the second comma run.
REQ-025 Lane 1 locked 3 bytes after lane 0 -> all_active rises on the same cycle as active_1.
REQ-026 In ACTIVE, send 8'hBC, 8'h33 -> strobes with valid_0=0 then valid_0=1, byte_0=8'h33.
REQ-027 reset asserted at bit 4 of a payload byte in ACTIVE -> all outputs are 0 next cycle; relock requires 4 fresh commas.
REQ-028 With PHY_RX_SYNC_LOS_EN, eight 8'h00 bytes in ACTIVE -> active_0 falls at the 8th byte; seven 8'h00 then 8'h22 -> the lane stays ACTIVE.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared lane state encoding and default alignment constants for the two-lane RX sync controller.
package phy_rx_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      LOCK   = 2'd1,
      ACTIVE = 2'd2
   } lane_state_e;

   localparam logic [7:0] DEF_COMMA     = 8'hBC;
   localparam int         DEF_BC_COUNT  = 4;
   localparam int         DEF_LOS_LIMIT = 8;

endpackage

// File: rtl/phy_rx_lane_sync.sv
// One lane of byte alignment: comma search, comma-run lock, aligned byte output.
// Optional loss-of-sync on stuck 8'h00/8'hFF bytes when PHY_RX_SYNC_LOS_EN is defined.
module phy_rx_lane_sync
   import phy_rx_pkg::*;
#(
   parameter logic [7:0] COMMA     = DEF_COMMA,
   parameter int         BC_COUNT  = DEF_BC_COUNT,
   parameter int         LOS_LIMIT = DEF_LOS_LIMIT
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] byte_out,
   output logic       strobe,
   output logic       valid,
   output logic       active,
   output logic [1:0] state_dbg
);

   localparam int BCW = $clog2(BC_COUNT + 1);

   if (BC_COUNT < 1 || LOS_LIMIT < 1) begin : g_bad_cfg
      $error("phy_rx_lane_sync: BC_COUNT and LOS_LIMIT must be at least 1");
   end

   lane_state_e      state, state_n;
   logic [7:0]       sr, nxt;
   logic [2:0]       bit_cnt, bit_n;
   logic [BCW-1:0]   bc_cnt, bc_n;
   logic [7:0]       byte_q, byte_n;
   logic             strobe_q, strobe_n;
   logic             valid_q, valid_n;
   logic             boundary;

`ifdef PHY_RX_SYNC_LOS_EN
   localparam int LSW = $clog2(LOS_LIMIT + 1);
   logic [LSW-1:0]   los_cnt, los_n;
`endif

   assign nxt      = {sr[6:0], data_in};
   assign boundary = (bit_cnt == 3'd7);

   always_comb begin
      state_n  = state;
      bit_n    = bit_cnt + 3'd1;
      bc_n     = bc_cnt;
      byte_n   = byte_q;
      strobe_n = 1'b0;
      valid_n  = valid_q;
`ifdef PHY_RX_SYNC_LOS_EN
      los_n    = los_cnt;
`endif
      case (state)
         SEARCH: begin
            bit_n   = 3'd0;
            bc_n    = '0;
            valid_n = 1'b0;
            if (nxt == COMMA) begin
               bc_n    = BCW'(1);
               state_n = (BC_COUNT == 1) ? ACTIVE : LOCK;
            end
         end
         LOCK: begin
            valid_n = 1'b0;
            if (boundary) begin
               if (nxt == COMMA) begin
                  // Saturate at BC_COUNT: the lane leaves LOCK on that same boundary.
                  if (int'(bc_cnt) + 1 >= BC_COUNT) begin
                     bc_n    = BCW'(BC_COUNT);
                     state_n = ACTIVE;
                  end else begin
                     bc_n = bc_cnt + BCW'(1);
                  end
               end else begin
                  bc_n    = '0;
                  state_n = SEARCH;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               byte_n   = nxt;
               strobe_n = 1'b1;
               valid_n  = (nxt != COMMA);
`ifdef PHY_RX_SYNC_LOS_EN
               if (nxt == 8'h00 || nxt == 8'hFF) begin
                  if (int'(los_cnt) + 1 >= LOS_LIMIT) begin
                     // Losing sync on this boundary: nothing from the stuck byte is presented.
                     state_n  = SEARCH;
                     byte_n   = byte_q;
                     strobe_n = 1'b0;
                     valid_n  = 1'b0;
                     bc_n     = '0;
                     los_n    = '0;
                  end else begin
                     los_n = los_cnt + LSW'(1);
                  end
               end else begin
                  los_n = '0;
               end
`endif
            end
         end
         default: begin
            state_n = SEARCH;
            bc_n    = '0;
            valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state    <= SEARCH;
         sr       <= '0;
         bit_cnt  <= '0;
         bc_cnt   <= '0;
         byte_q   <= '0;
         strobe_q <= 1'b0;
         valid_q  <= 1'b0;
`ifdef PHY_RX_SYNC_LOS_EN
         los_cnt  <= '0;
`endif
      end else begin
         state    <= state_n;
         sr       <= nxt;
         bit_cnt  <= bit_n;
         bc_cnt   <= bc_n;
         byte_q   <= byte_n;
         strobe_q <= strobe_n;
         valid_q  <= valid_n;
`ifdef PHY_RX_SYNC_LOS_EN
         los_cnt  <= los_n;
`endif
      end
   end

   assign byte_out  = byte_q;
   assign strobe    = strobe_q;
   assign valid     = valid_q;
   assign active    = (state == ACTIVE);
   assign state_dbg = state;

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Two independent byte-alignment lanes plus a combined all-lanes-active flag.
// Define PHY_RX_SYNC_LOS_EN to enable loss-of-sync detection on stuck lanes.
module phy_rx_sync_ctrl
   import phy_rx_pkg::*;
#(
   parameter logic [7:0] COMMA     = DEF_COMMA,
   parameter int         BC_COUNT  = DEF_BC_COUNT,
   parameter int         LOS_LIMIT = DEF_LOS_LIMIT
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_in0,
   input  logic       data_in1,
   output logic [7:0] byte_0,
   output logic [7:0] byte_1,
   output logic       strobe_0,
   output logic       strobe_1,
   output logic       valid_0,
   output logic       valid_1,
   output logic       active_0,
   output logic       active_1,
   output logic       all_active
);

   logic [1:0] state_0, state_1;

   phy_rx_lane_sync #(.COMMA(COMMA), .BC_COUNT(BC_COUNT), .LOS_LIMIT(LOS_LIMIT)) u_lane0 (
      .clk_8f    (clk_8f),
      .reset     (reset),
      .data_in   (data_in0),
      .byte_out  (byte_0),
      .strobe    (strobe_0),
      .valid     (valid_0),
      .active    (active_0),
      .state_dbg (state_0)
   );

   phy_rx_lane_sync #(.COMMA(COMMA), .BC_COUNT(BC_COUNT), .LOS_LIMIT(LOS_LIMIT)) u_lane1 (
      .clk_8f    (clk_8f),
      .reset     (reset),
      .data_in   (data_in1),
      .byte_out  (byte_1),
      .strobe    (strobe_1),
      .valid     (valid_1),
      .active    (active_1),
      .state_dbg (state_1)
   );

   // Same-cycle AND of the two registered lane states.
   assign all_active = (state_0 == ACTIVE) && (state_1 == ACTIVE);

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed bench for phy_rx_sync_ctrl: strobed bytes are checked against an expected queue per lane.
module tb_phy_rx_sync_ctrl;

   localparam logic [7:0] COMMA = 8'hBC;

   logic       clk_8f = 1'b0;
   logic       reset  = 1'b1;
   logic       d0 = 1'b0, d1 = 1'b0;
   logic [7:0] byte_0, byte_1, b1_byte_0, b1_byte_1;
   logic       strobe_0, strobe_1, valid_0, valid_1, active_0, active_1, all_active;
   logic       b1_strobe_0, b1_strobe_1, b1_valid_0, b1_valid_1;
   logic       b1_active_0, b1_active_1, b1_all_active;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [8:0] exp_q0[$];
   logic [8:0] exp_q1[$];

   // clock / reset
   always #5 clk_8f = ~clk_8f;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   phy_rx_sync_ctrl dut (
      .clk_8f(clk_8f), .reset(reset), .data_in0(d0), .data_in1(d1),
      .byte_0(byte_0), .byte_1(byte_1), .strobe_0(strobe_0), .strobe_1(strobe_1),
      .valid_0(valid_0), .valid_1(valid_1), .active_0(active_0), .active_1(active_1),
      .all_active(all_active)
   );

   phy_rx_sync_ctrl #(.BC_COUNT(1)) dut_b1 (
      .clk_8f(clk_8f), .reset(reset), .data_in0(d0), .data_in1(d1),
      .byte_0(b1_byte_0), .byte_1(b1_byte_1), .strobe_0(b1_strobe_0), .strobe_1(b1_strobe_1),
      .valid_0(b1_valid_0), .valid_1(b1_valid_1), .active_0(b1_active_0), .active_1(b1_active_1),
      .all_active(b1_all_active)
   );

   // scoreboard helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk_8f) begin
      #1;
      if (strobe_0) begin
         if (exp_q0.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL lane0_strobe: unexpected strobe byte %0h valid %0b", byte_0, valid_0);
         end else chk("lane0_byte", {23'd0, valid_0, byte_0}, {23'd0, exp_q0.pop_front()});
      end
      if (strobe_1) begin
         if (exp_q1.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL lane1_strobe: unexpected strobe byte %0h valid %0b", byte_1, valid_1);
         end else chk("lane1_byte", {23'd0, valid_1, byte_1}, {23'd0, exp_q1.pop_front()});
      end
   end

   // drivers
   task automatic tick;
      @(posedge clk_8f); #1;
   endtask

   task automatic send_bits0(input logic [7:0] b, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         @(negedge clk_8f); d0 = b[i];
      end
   endtask

   task automatic send_byte0(input logic [7:0] b, input bit push);
      if (push) exp_q0.push_back({b != COMMA, b});
      send_bits0(b, 7, 0);
   endtask

   task automatic send_byte1(input logic [7:0] b, input bit push);
      if (push) exp_q1.push_back({b != COMMA, b});
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk_8f); d1 = b[i];
      end
   endtask

   task automatic lock0;
      for (int k = 0; k < 4; k++) send_byte0(COMMA, 1'b0);
   endtask

   task automatic do_reset;
      @(negedge clk_8f); reset = 1'b1; d0 = 1'b0; d1 = 1'b0;
      @(negedge clk_8f); reset = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_byte_0"},   {24'd0, byte_0}, 32'h0);
      chk({tag, "_byte_1"},   {24'd0, byte_1}, 32'h0);
      chk({tag, "_strobe_0"}, {31'd0, strobe_0}, 32'h0);
      chk({tag, "_valid_0"},  {31'd0, valid_0}, 32'h0);
      chk({tag, "_active_0"}, {31'd0, active_0}, 32'h0);
      chk({tag, "_active_1"}, {31'd0, active_1}, 32'h0);
      chk({tag, "_all_active"}, {31'd0, all_active}, 32'h0);
   endtask

   initial begin
      repeat (3) @(negedge clk_8f);
      reset = 1'b0;
      tick;
      chk_all_zero("reset");

      // Four commas then 5A: lock, then a strobe exactly 8 cycles later.
      send_byte0(COMMA, 1'b0);
      tick;
      chk("b1_direct_active", {31'd0, b1_active_0}, 32'd1);
      chk("bc4_after_1", {31'd0, active_0}, 32'd0);
      send_byte0(COMMA, 1'b0);
      send_byte0(COMMA, 1'b0);
      tick;
      chk("bc4_after_3", {31'd0, active_0}, 32'd0);
      send_byte0(COMMA, 1'b0);
      tick;
      chk("bc4_after_4", {31'd0, active_0}, 32'd1);
      chk("all_active_one_lane", {31'd0, all_active}, 32'd0);
      exp_q0.push_back({1'b1, 8'h5A});
      send_bits0(8'h5A, 7, 1);
      tick;
      chk("strobe_early", {31'd0, strobe_0}, 32'd0);
      send_bits0(8'h5A, 0, 0);
      tick;
      chk("strobe_at_8", {31'd0, strobe_0}, 32'd1);
      tick;
      chk("strobe_one_cycle", {31'd0, strobe_0}, 32'd0);
      chk("byte_hold", {24'd0, byte_0}, 32'h5A);
      chk("valid_hold", {31'd0, valid_0}, 32'd1);
      do_reset;

      // Broken comma run falls back to SEARCH; relock needs a full fresh run.
      for (int k = 0; k < 3; k++) send_byte0(COMMA, 1'b0);
      send_byte0(8'h11, 1'b0);
      tick;
      chk("break_active", {31'd0, active_0}, 32'd0);
      for (int k = 0; k < 3; k++) send_byte0(COMMA, 1'b0);
      tick;
      chk("relock_after_3", {31'd0, active_0}, 32'd0);
      send_byte0(COMMA, 1'b0);
      tick;
      chk("relock_after_4", {31'd0, active_0}, 32'd1);
      do_reset;

      // Lane 1 locks three bytes after lane 0.
      fork
         begin
            lock0;
            for (int k = 1; k <= 7; k++) send_byte0(8'(k), 1'b1);
         end
         begin
            repeat (24) begin @(negedge clk_8f); d1 = 1'b0; end
            for (int k = 0; k < 3; k++) send_byte1(COMMA, 1'b0);
            tick;
            chk("lane1_after_3", {31'd0, active_1}, 32'd0);
            chk("all_before", {31'd0, all_active}, 32'd0);
            send_byte1(COMMA, 1'b0);
            tick;
            chk("lane1_after_4", {31'd0, active_1}, 32'd1);
            chk("all_with_lane1", {31'd0, all_active}, 32'd1);
            for (int k = 0; k < 4; k++) send_byte1(8'hA1 + 8'(k), 1'b1);
         end
      join
      do_reset;

      // Comma inside ACTIVE is strobed but not valid.
      lock0;
      send_byte0(COMMA, 1'b1);
      send_byte0(8'h33, 1'b1);
      tick;
      chk("payload_valid", {31'd0, valid_0}, 32'd1);
      chk("payload_byte", {24'd0, byte_0}, 32'h33);
      do_reset;

      // Reset in the middle of a payload byte clears everything.
      lock0;
      send_byte0(8'h77, 1'b1);
      send_bits0(8'h5A, 7, 4);
      @(negedge clk_8f); reset = 1'b1; d0 = 1'b0;
      tick;
      chk_all_zero("midreset");
      @(negedge clk_8f); reset = 1'b0;
      for (int k = 0; k < 3; k++) send_byte0(COMMA, 1'b0);
      tick;
      chk("postreset_after_3", {31'd0, active_0}, 32'd0);
      send_byte0(COMMA, 1'b0);
      tick;
      chk("postreset_after_4", {31'd0, active_0}, 32'd1);
      do_reset;

`ifdef PHY_RX_SYNC_LOS_EN
      // Seven stuck bytes then real data keeps lock; eight stuck bytes lose it.
      lock0;
      for (int k = 0; k < 7; k++) send_byte0(8'h00, 1'b1);
      send_byte0(8'h22, 1'b1);
      tick;
      chk("los_seven_active", {31'd0, active_0}, 32'd1);
      for (int k = 0; k < 7; k++) send_byte0(8'h00, 1'b1);
      tick;
      chk("los_before_8th", {31'd0, active_0}, 32'd1);
      send_byte0(8'h00, 1'b0);
      tick;
      chk("los_eight_active", {31'd0, active_0}, 32'd0);
      chk("los_eight_strobe", {31'd0, strobe_0}, 32'd0);
      chk("los_eight_valid", {31'd0, valid_0}, 32'd0);
      do_reset;
`endif

      repeat (4) tick;
      chk("lane0_queue_drained", exp_q0.size(), 32'd0);
      chk("lane1_queue_drained", exp_q1.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
